ctrl_pipe: RTL
==============

# ctrl_pipe

Parametrised, multi-stage control-signal pipeline carrying per-instruction control words (register write enable, memory read/write, writeback select, …) from decode towards writeback. It generalises the single EX/MEM control register to DEPTH stages of WIDTH bits, each with its own valid bit, stall and flush. It adds a debugger-driven drain/halt/resume sequence, so the external debug unit can quiesce the pipeline before taking control.

## Interface
- WIDTH, 5, control-word width per stage; the default packs reg_WEn, Mem_R, Mem_W and WB_sel[1:0].
- DEPTH, 2, number of pipeline stages (≥1); stage 0 is the input stage and stage DEPTH-1 drives the outputs.
- CW, $clog2(DEPTH+1), occupancy width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_ctrl  in  WIDTH  control word offered to stage 0.
- in_valid  in  1  in_ctrl carries a real instruction.
- in_ready  out  1  stage 0 accepts this cycle (combinational).
- stall  in  DEPTH  per-stage hold request; bit i holds stage i.
- flush  in  DEPTH  per-stage kill; bit i zeroes stage i at the next edge.
- halt_req  in  1  debugger request to drain and halt (level, sampled each cycle).
- resume_req  in  1  debugger request to resume (level, sampled each cycle).
- out_ctrl  out  WIDTH  stage DEPTH-1 control word.
- out_valid  out  1  stage DEPTH-1 valid bit.
- stage_valid  out  DEPTH  valid bit of every stage.
- occupancy  out  CW  number of valid stages (popcount of stage_valid).
- halted  out  1  the FSM is in the HALTED state (registered).

## Operation
- Invariant: a stage's control word is all-zero whenever its valid bit is 0. Bubbles are therefore no-ops downstream.
- Effective hold: h[DEPTH-1] = stall[DEPTH-1]; h[i] = stall[i] | h[i+1]. A stall freezes its own stage and every upstream stage.
- Stage i > 0 update priority:
  - flush[i] → zero;
  - else h[i] → keep;
  - else h[i-1] → bubble (zero);
  - else load stage i-1.
- Stage 0 update priority:
  - flush[0] → zero;
  - else h[0] → keep;
  - else if state is RUN and in_valid → {in_ctrl, valid=1};
  - else → bubble.
- in_ready = (state == RUN) & ~h[0]. The in_valid & in_ready pair is the only accept condition.
- Flush dominates stall for the same stage. Flush does not alter h, so a flushed held stage still blocks upstream for that cycle.
- FSM states and transitions:
  - RUN: halt_req → DRAIN. The accept in the halt_req cycle itself is still honoured.
  - DRAIN: no new entries are accepted; stalls and flushes are still obeyed.
    - resume_req → RUN (abort drain).
    - else, if all stage_valid bits are 0 → HALTED.
  - HALTED: stages hold zero; halted = 1. resume_req → RUN, with priority over a simultaneous halt_req.
- occupancy is a combinational popcount of the stage valid registers.

## Timing
- Reset (asynchronous, immediate): all stage words and valid bits = 0; state = RUN.
  - Outputs: out_ctrl = 0, out_valid = 0, stage_valid = 0, occupancy = 0, halted = 0.
  - in_ready = ~h[0].
- Latency with no stalls: an entry accepted at edge t appears on out_ctrl/out_valid after edge t+DEPTH-1. Example: DEPTH=2 → output valid one cycle after acceptance.
- Throughput: one entry per cycle when no stall is active.
- Stall and flush act at the next rising edge; outputs change only after an edge.
- Halt timing with an empty pipe and halt_req at cycle t:
  - DRAIN from t+1;
  - HALTED from t+2 (halted high).
- Each valid entry still in flight adds one cycle per stage it must traverse. Downstream stalls extend the drain accordingly.
- Resume: resume_req in HALTED at cycle t → RUN and in_ready high from t+1 (if no stall).
- rst_n asserted mid-drain or while halted returns to RUN with an empty pipe; no partial state is retained.

## Test plan
1. Async reset: fill DEPTH=2 with 5'h1F, then drop rst_n between edges → out_ctrl = 0, out_valid = 0, halted = 0, occupancy = 0 immediately, before the next edge.
2. Streaming (DEPTH=2): accept 5'h15 at edge 0 and 5'h0A at edge 1 → out_ctrl = 5'h15 with out_valid = 1 after edge 1; 5'h0A after edge 2; with in_valid low afterwards, out_valid = 0 after edge 3.
3. Stall propagation, pipe full (A in stage 1, B in stage 0):
   - stall = 2'b10 for 2 cycles → both stages frozen, in_ready = 0, out_ctrl = A stable;
   - then stall = 2'b01 for 1 cycle → stage 1 = bubble (out_valid = 0, out_ctrl = 0), B is kept in stage 0.
4. Flush dominance: stall = 2'b01 and flush = 2'b01 in the same cycle → stage 0 zeroed and stage_valid[0] = 0 next cycle; stage 1 receives a bubble.
5. Halt/resume: stages holding A and B, in_valid = 0, halt_req pulsed at cycle t:
   - out_valid shows B at t+1;
   - pipe empty at t+2;
   - halted = 1 from t+3;
   - resume_req at t+5 → halted = 0 and in_ready = 1 at t+6.
6. Corner requests:
   - resume_req during DRAIN → RUN next cycle, with accepts re-enabled;
   - halt_req and resume_req together in HALTED → RUN;
   - stall held high through DRAIN → halted stays 0 until the stall releases and the pipe empties.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: multi-stage control-word pipeline with per-stage stall/flush and debugger drain/halt/resume.
module ctrl_pipe #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_ctrl,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEPTH-1:0] stall,
    input  logic [DEPTH-1:0] flush,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic [WIDTH-1:0] out_ctrl,
    output logic             out_valid,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CW-1:0]    occupancy,
    output logic             halted
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
    state_e state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0] word_q, word_d;
    logic [DEPTH-1:0] valid_q, valid_d, h;
    logic accept;
    assign in_ready = (state_q == RUN) && !h[0];
    assign accept = in_valid && in_ready;
    always_comb begin
        h = stall;
        for (int k = DEPTH - 2; k >= 0; k--) h[k] = stall[k] | h[k+1];
        valid_d[0] = flush[0] ? 1'b0 : h[0] ? valid_q[0] : accept;
        word_d[0] = flush[0] ? '0 : h[0] ? word_q[0] : accept ? in_ctrl : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = flush[k] ? 1'b0 : h[k] ? valid_q[k] : h[k-1] ? 1'b0 : valid_q[k-1];
            word_d[k] = flush[k] ? '0 : h[k] ? word_q[k] : h[k-1] ? '0 : word_q[k-1];
        end
    end
    // resume wins over everything outside RUN; DRAIN completes only once every stage is empty
    always_comb begin
        state_d = (state_q != RUN && resume_req) ? RUN :
                  (state_q == RUN && halt_req) ? DRAIN :
                  (state_q == DRAIN && !(|valid_q)) ? HALTED : state_q;
    end
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) occupancy = occupancy + CW'(valid_q[k]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            word_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            word_q <= word_d;
            valid_q <= valid_d;
        end
    end
    assign out_ctrl = word_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign halted = (state_q == HALTED);
endmodule
